// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the RISC-V lite core.
//
// Drives the instruction memory with the current PC and captures the combinational read
// data in the same cycle. Each fetched {pc, instr} pair goes into a DEPTH-entry FIFO, and
// decode drains that FIFO over a valid/ready handshake. A redirect from execute flushes
// the FIFO and restarts fetch at the new PC.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   - Defined: a redirect to a target that is not word-aligned loads the PC unchanged,
//     halts fetch and raises FETCH_ERR. A later aligned redirect, or RST, clears both.
//   - Undefined: the redirect target is force-aligned and FETCH_ERR is tied to 0.
//
// Parameters:
//   DEPTH     FIFO entries; must be a power of two and at least 2.
//   RESET_PC  PC value loaded on reset.
//
// Ports:
//   CLK             clock; all state updates on the rising edge
//   RST             synchronous active-high reset
//   IMEM_ADDR       byte address to instruction memory (always the PC register)
//   IMEM_RDATA      combinational instruction word for IMEM_ADDR
//   IMEM_REQ        high in any cycle where IMEM_RDATA is pushed into the FIFO
//   REDIRECT_VALID  redirect request from execute; flushes the FIFO
//   REDIRECT_PC     redirect target
//   OUT_VALID       FIFO head is valid
//   OUT_READY       decode accepts the head
//   OUT_INSTR       head instruction (0 while the FIFO is empty)
//   OUT_PC          head PC (0 while the FIFO is empty)
//   FETCH_ERR       misaligned-redirect error flag
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  output logic        IMEM_REQ,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_INSTR,
  output logic [31:0] OUT_PC,
  output logic        FETCH_ERR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DepthCnt = PW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;
  logic          halt;
  logic          fetch;
  logic          pop;

  assign pop   = OUT_VALID && OUT_READY;
  assign fetch = !RST && !REDIRECT_VALID && !halt && ((count_q < DepthCnt) || pop);

  assign IMEM_ADDR = pc_q;
  assign IMEM_REQ  = fetch;

  // Gate the head so that an empty FIFO presents zeros instead of stale storage.
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign OUT_VALID = (count_q != '0);
  assign OUT_PC    = OUT_VALID ? head[63:32] : 32'h0;
  assign OUT_INSTR = OUT_VALID ? head[31:0] : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (REDIRECT_VALID) begin
      // A flush wins over any push or pop in the same cycle.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      pc_d     = REDIRECT_PC;
`else
      pc_d     = {REDIRECT_PC[31:2], 2'b00};
`endif
    end else begin
      if (fetch) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({fetch, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset: every entry is written before it can become the head.
  always_ff @(posedge CLK) begin
    if (fetch) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {pc_q, IMEM_RDATA};
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q, halt_d;
  logic err_q, err_d;

  always_comb begin
    halt_d = halt_q;
    err_d  = err_q;
    if (REDIRECT_VALID) begin
      halt_d = (REDIRECT_PC[1:0] != 2'b00);
      err_d  = (REDIRECT_PC[1:0] != 2'b00);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      halt_q <= halt_d;
      err_q  <= err_d;
    end
  end

  assign halt      = halt_q;
  assign FETCH_ERR = err_q;
`else
  // The target's low bits are discarded when alignment is forced.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  assign halt      = 1'b0;
  assign FETCH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Instruction memory is modelled as read data = address + 1, with RESET_PC = 0.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_REQ;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INSTR;
  logic [31:0] OUT_PC;
  logic        FETCH_ERR;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_RDATA     (IMEM_RDATA),
    .IMEM_REQ       (IMEM_REQ),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .OUT_VALID      (OUT_VALID),
    .OUT_READY      (OUT_READY),
    .OUT_INSTR      (OUT_INSTR),
    .OUT_PC         (OUT_PC),
    .FETCH_ERR      (FETCH_ERR)
  );

  // fakemem
  assign IMEM_RDATA = IMEM_ADDR + 32'd1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'h0, OUT_VALID}, 32'd1);
    check({tag, "_pc"}, OUT_PC, pc);
    check({tag, "_instr"}, OUT_INSTR, pc + 32'd1);
  endtask

  initial begin
    RST            = 1'b1;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC    = 32'h0;
    OUT_READY      = 1'b0;
    tick();
    settle();

    // Reset state
    check("rst_valid", {31'h0, OUT_VALID}, 32'd0);
    check("rst_instr", OUT_INSTR, 32'h0);
    check("rst_pc", OUT_PC, 32'h0);
    check("rst_err", {31'h0, FETCH_ERR}, 32'd0);
    check("rst_req", {31'h0, IMEM_REQ}, 32'd0);
    check("rst_addr", IMEM_ADDR, 32'h0);

    // Stream: one pair per cycle with OUT_READY held high
    RST       = 1'b0;
    OUT_READY = 1'b1;
    settle();
    check("strm_req0", {31'h0, IMEM_REQ}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_head("strm", 32'(4 * (k - 1)));
    end

    // Backpressure: FIFO fills after 4 fetches, then drains with no gap
    RST       = 1'b1;
    OUT_READY = 1'b0;
    tick();
    RST = 1'b0;
    settle();
    tick();
    tick();
    tick();
    tick();
    check("bp_req_full", {31'h0, IMEM_REQ}, 32'd0);
    check("bp_addr_full", IMEM_ADDR, 32'd16);
    check_head("bp_hold", 32'h0);
    tick();
    check("bp_req_full2", {31'h0, IMEM_REQ}, 32'd0);
    check("bp_addr_full2", IMEM_ADDR, 32'd16);
    check_head("bp_hold2", 32'h0);
    OUT_READY = 1'b1;
    settle();
    check("bp_req_full_pop", {31'h0, IMEM_REQ}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_head("bp_drain", 32'(4 * k));
    end

    // Redirect with 3 entries buffered; the head is discarded despite OUT_READY
    RST       = 1'b1;
    OUT_READY = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    tick();
    tick();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h100;
    OUT_READY      = 1'b1;
    settle();
    check("rd_req", {31'h0, IMEM_REQ}, 32'd0);
    tick();
    REDIRECT_VALID = 1'b0;
    settle();
    check("rd_valid", {31'h0, OUT_VALID}, 32'd0);
    check("rd_addr", IMEM_ADDR, 32'h100);
    tick();
    check_head("rd_first", 32'h100);
    tick();
    check_head("rd_second", 32'h104);

    // Reset mid-stream with 2 entries buffered
    OUT_READY = 1'b0;
    RST       = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    tick();
    check_head("mr_pre", 32'h0);
    RST = 1'b1;
    settle();
    check("mr_req", {31'h0, IMEM_REQ}, 32'd0);
    tick();
    RST       = 1'b0;
    OUT_READY = 1'b1;
    settle();
    check("mr_valid", {31'h0, OUT_VALID}, 32'd0);
    check("mr_pc", OUT_PC, 32'h0);
    check("mr_instr", OUT_INSTR, 32'h0);
    check("mr_addr", IMEM_ADDR, 32'h0);
    check("mr_err", {31'h0, FETCH_ERR}, 32'd0);
    tick();
    check_head("mr_restart", 32'h0);
    tick();
    check_head("mr_restart2", 32'h4);

    // Wrap from the top of the address space
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'hFFFF_FFFC;
    tick();
    REDIRECT_VALID = 1'b0;
    settle();
    check("wr_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    tick();
    check_head("wr_top", 32'hFFFF_FFFC);
    tick();
    check_head("wr_zero", 32'h0);

    // Misaligned redirect
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h102;
    tick();
    REDIRECT_VALID = 1'b0;
    settle();
`ifdef FETCH_MISALIGN_CHECK_EN
    check("ma_err", {31'h0, FETCH_ERR}, 32'd1);
    check("ma_req", {31'h0, IMEM_REQ}, 32'd0);
    check("ma_valid", {31'h0, OUT_VALID}, 32'd0);
    check("ma_addr", IMEM_ADDR, 32'h102);
    tick();
    tick();
    check("ma_err_hold", {31'h0, FETCH_ERR}, 32'd1);
    check("ma_req_hold", {31'h0, IMEM_REQ}, 32'd0);
    check("ma_valid_hold", {31'h0, OUT_VALID}, 32'd0);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h106;
    tick();
    REDIRECT_VALID = 1'b0;
    settle();
    check("ma2_err", {31'h0, FETCH_ERR}, 32'd1);
    check("ma2_req", {31'h0, IMEM_REQ}, 32'd0);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h200;
    tick();
    REDIRECT_VALID = 1'b0;
    settle();
    check("ma_rec_err", {31'h0, FETCH_ERR}, 32'd0);
    check("ma_rec_addr", IMEM_ADDR, 32'h200);
    check("ma_rec_req", {31'h0, IMEM_REQ}, 32'd1);
    tick();
    check_head("ma_rec_head", 32'h200);
`else
    check("ma_err", {31'h0, FETCH_ERR}, 32'd0);
    check("ma_addr", IMEM_ADDR, 32'h100);
    check("ma_valid", {31'h0, OUT_VALID}, 32'd0);
    tick();
    check_head("ma_head", 32'h100);
    tick();
    check_head("ma_head2", 32'h104);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
